// File: rtl/frog_motion_controller.sv
// Frame-tick frog FSM: key levels -> 40-px hops, pad riding, car/water deaths, lives and goal scoring.
// Latency: state changes one Clk after the internal tick (4 Clk after a frame_clk rise); no backpressure, inputs sampled on ticks only.
module frog_motion_controller #(
    parameter logic [10:0] START_X      = 11'd320,
    parameter logic [10:0] START_Y      = 11'd440,
    parameter logic [10:0] HOP_STEP     = 11'd8,
    parameter logic [10:0] HOP_PX       = 11'd40,
    parameter logic [10:0] MAX_X        = 11'd600,
    parameter logic [10:0] GOAL_Y       = 11'd40,
    parameter logic [10:0] WATER_TOP    = 11'd80,
    parameter logic [10:0] WATER_BOT    = 11'd200,
    parameter logic [7:0]  DEATH_FRAMES = 8'd60,
    parameter logic [1:0]  LIVES        = 2'd3
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        restart,
    input  logic [3:0]  Car_Collision,
    input  logic [3:0]  LPad_Collision,
    input  logic [3:0]  ride_dx,
    output logic [10:0] FrogX,
    output logic [10:0] FrogY,
    output logic [10:0] Frog_Width,
    output logic [10:0] Frog_Height,
    output logic [1:0]  cur_Frog_Direction,
    output logic [1:0]  lives,
    output logic [6:0]  score,
    output logic        dead,
    output logic        game_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOP,
        S_WAIT_REL,
        S_DEAD,
        S_GAMEOVER
    } state_t;

    localparam int          HOP_TICKS = int'(HOP_PX / HOP_STEP);
    localparam logic [7:0]  HOP_LAST  = 8'(HOP_TICKS - 1);
    localparam logic signed [11:0] HOP_S   = {1'b0, HOP_PX};
    localparam logic signed [11:0] MAX_X_S = {1'b0, MAX_X};
    localparam logic signed [11:0] GOAL_S  = {1'b0, GOAL_Y};
    localparam logic signed [11:0] START_S = {1'b0, START_Y};

    state_t      state_q, state_nxt;
    logic [10:0] x_q, x_nxt, y_q, y_nxt, tgt_x_q, tgt_x_nxt, tgt_y_q, tgt_y_nxt;
    logic [1:0]  dir_q, dir_nxt, lives_q, lives_nxt, lives_dec;
    logic [6:0]  score_q, score_nxt;
    logic        dead_q, dead_nxt, go_q, go_nxt;
    logic [7:0]  hop_cnt_q, hop_cnt_nxt, death_cnt_q, death_cnt_nxt;
    logic        fclk_s1, fclk_s2, fclk_s3, tick;

    // Two-flop synchroniser, then a registered rising-edge pulse.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fclk_s1 <= 1'b0;
            fclk_s2 <= 1'b0;
            fclk_s3 <= 1'b0;
            tick    <= 1'b0;
        end else begin
            fclk_s1 <= frame_clk;
            fclk_s2 <= fclk_s1;
            fclk_s3 <= fclk_s2;
            tick    <= fclk_s2 & ~fclk_s3;
        end
    end

    logic               car_hit, on_pad, water_death, any_key, key_ok;
    logic [1:0]         key_dir;
    logic signed [11:0] x_s, y_s, ride_ext, ride_sum, key_tx, key_ty;
    logic [10:0]        ride_x;

    always_comb begin
        car_hit     = |Car_Collision;
        on_pad      = |LPad_Collision;
        water_death = (y_q >= WATER_TOP) && (y_q <= WATER_BOT) && !on_pad;
        any_key     = up | down | left | right;
        x_s         = {1'b0, x_q};
        y_s         = {1'b0, y_q};
        ride_ext    = {{8{ride_dx[3]}}, ride_dx};
        ride_sum    = x_s + ride_ext;
        if (ride_sum < 12'sd0)
            ride_x = 11'd0;
        else if (ride_sum > MAX_X_S)
            ride_x = MAX_X;
        else
            ride_x = ride_sum[10:0];

        key_dir = 2'b00;
        key_tx  = x_s;
        key_ty  = y_s;
        key_ok  = 1'b0;
        if (up) begin
            key_dir = 2'b00;
            key_ty  = y_s - HOP_S;
            key_ok  = key_ty >= GOAL_S;
        end else if (down) begin
            key_dir = 2'b01;
            key_ty  = y_s + HOP_S;
            key_ok  = key_ty <= START_S;
        end else if (left) begin
            key_dir = 2'b11;
            key_tx  = x_s - HOP_S;
            key_ok  = key_tx >= 12'sd0;
        end else if (right) begin
            key_dir = 2'b10;
            key_tx  = x_s + HOP_S;
            key_ok  = key_tx <= MAX_X_S;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        x_nxt         = x_q;
        y_nxt         = y_q;
        dir_nxt       = dir_q;
        lives_nxt     = lives_q;
        score_nxt     = score_q;
        dead_nxt      = dead_q;
        go_nxt        = go_q;
        hop_cnt_nxt   = hop_cnt_q;
        death_cnt_nxt = death_cnt_q;
        tgt_x_nxt     = tgt_x_q;
        tgt_y_nxt     = tgt_y_q;
        lives_dec     = lives_q - 2'd1;
        if (tick) begin
            unique case (state_q)
                S_IDLE, S_WAIT_REL: begin
                    if (car_hit || water_death) begin
                        state_nxt     = S_DEAD;
                        dead_nxt      = 1'b1;
                        death_cnt_nxt = 8'd0;
                    end else if (state_q == S_IDLE && any_key) begin
                        dir_nxt = key_dir;
                        if (key_ok) begin
                            state_nxt   = S_HOP;
                            hop_cnt_nxt = 8'd0;
                            tgt_x_nxt   = key_tx[10:0];
                            tgt_y_nxt   = key_ty[10:0];
                        end else begin
                            state_nxt = S_WAIT_REL;
                        end
                    end else begin
                        if (on_pad)
                            x_nxt = ride_x;
                        if (state_q == S_WAIT_REL && !any_key)
                            state_nxt = S_IDLE;
                    end
                end
                S_HOP: begin
                    // Car check precedes landing, so a hit on the last step scores nothing.
                    if (car_hit) begin
                        state_nxt     = S_DEAD;
                        dead_nxt      = 1'b1;
                        death_cnt_nxt = 8'd0;
                    end else if (hop_cnt_q == HOP_LAST) begin
                        state_nxt = S_WAIT_REL;
                        if (tgt_y_q == GOAL_Y) begin
                            if (score_q < 7'd99)
                                score_nxt = score_q + 7'd1;
                            x_nxt   = START_X;
                            y_nxt   = START_Y;
                            dir_nxt = 2'b00;
                        end else begin
                            x_nxt = tgt_x_q;
                            y_nxt = tgt_y_q;
                        end
                    end else begin
                        hop_cnt_nxt = hop_cnt_q + 8'd1;
                        case (dir_q)
                            2'b00:   y_nxt = y_q - HOP_STEP;
                            2'b01:   y_nxt = y_q + HOP_STEP;
                            2'b10:   x_nxt = x_q + HOP_STEP;
                            default: x_nxt = x_q - HOP_STEP;
                        endcase
                    end
                end
                S_DEAD: begin
                    if (death_cnt_q == DEATH_FRAMES - 8'd1) begin
                        lives_nxt = lives_dec;
                        if (lives_dec == 2'd0) begin
                            state_nxt = S_GAMEOVER;
                            go_nxt    = 1'b1;
                        end else begin
                            state_nxt = S_WAIT_REL;
                            x_nxt     = START_X;
                            y_nxt     = START_Y;
                            dir_nxt   = 2'b00;
                            dead_nxt  = 1'b0;
                        end
                    end else begin
                        death_cnt_nxt = death_cnt_q + 8'd1;
                    end
                end
                S_GAMEOVER: begin
                    if (restart) begin
                        state_nxt = S_WAIT_REL;
                        lives_nxt = LIVES;
                        score_nxt = 7'd0;
                        x_nxt     = START_X;
                        y_nxt     = START_Y;
                        dir_nxt   = 2'b00;
                        dead_nxt  = 1'b0;
                        go_nxt    = 1'b0;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            x_q         <= START_X;
            y_q         <= START_Y;
            dir_q       <= 2'b00;
            lives_q     <= LIVES;
            score_q     <= 7'd0;
            dead_q      <= 1'b0;
            go_q        <= 1'b0;
            hop_cnt_q   <= 8'd0;
            death_cnt_q <= 8'd0;
            tgt_x_q     <= START_X;
            tgt_y_q     <= START_Y;
        end else begin
            state_q     <= state_nxt;
            x_q         <= x_nxt;
            y_q         <= y_nxt;
            dir_q       <= dir_nxt;
            lives_q     <= lives_nxt;
            score_q     <= score_nxt;
            dead_q      <= dead_nxt;
            go_q        <= go_nxt;
            hop_cnt_q   <= hop_cnt_nxt;
            death_cnt_q <= death_cnt_nxt;
            tgt_x_q     <= tgt_x_nxt;
            tgt_y_q     <= tgt_y_nxt;
        end
    end

    assign FrogX              = x_q;
    assign FrogY              = y_q;
    assign Frog_Width         = 11'd40;
    assign Frog_Height        = 11'd40;
    assign cur_Frog_Direction = dir_q;
    assign lives              = lives_q;
    assign score              = score_q;
    assign dead               = dead_q;
    assign game_over          = go_q;

endmodule

// File: tb/tb_frog_motion_controller.sv
// Directed bench for frog_motion_controller: stimulus pushes expected snapshots, a monitor pops and compares.
module tb_frog_motion_controller;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        frame_clk = 1'b0;
    logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, restart = 1'b0;
    logic [3:0]  Car_Collision = 4'd0, LPad_Collision = 4'd0, ride_dx = 4'd0;
    logic [10:0] FrogX, FrogY, Frog_Width, Frog_Height;
    logic [1:0]  cur_Frog_Direction, lives;
    logic [6:0]  score;
    logic        dead, game_over;

    frog_motion_controller dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .up(up), .down(down), .left(left), .right(right), .restart(restart),
        .Car_Collision(Car_Collision), .LPad_Collision(LPad_Collision), .ride_dx(ride_dx),
        .FrogX(FrogX), .FrogY(FrogY), .Frog_Width(Frog_Width), .Frog_Height(Frog_Height),
        .cur_Frog_Direction(cur_Frog_Direction), .lives(lives), .score(score),
        .dead(dead), .game_over(game_over)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [10:0] w;
        logic [10:0] h;
        logic [10:0] x;
        logic [10:0] y;
        logic [1:0]  dir;
        logic [1:0]  lives;
        logic [6:0]  score;
        logic        dead;
        logic        go;
    } snap_t;

    snap_t exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail = 0;

    // Expected-state model, updated by hand alongside the stimulus.
    int ex = 320, ey = 440, edir = 0, elives = 3, escore = 0, edead = 0, ego = 0;

    task automatic expect_now(input string nm);
        snap_t s;
        s.w = 11'd40; s.h = 11'd40;
        s.x = 11'(ex); s.y = 11'(ey); s.dir = 2'(edir); s.lives = 2'(elives);
        s.score = 7'(escore); s.dead = 1'(edead); s.go = 1'(ego);
        exp_q.push_back(s);
        name_q.push_back(nm);
    endtask

    // Monitor: outputs only move on ticks, so any negedge with a pending entry is a valid sample point.
    initial begin
        snap_t e, a;
        string nm;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {Frog_Width, Frog_Height, FrogX, FrogY, cur_Frog_Direction, lives, score, dead, game_over};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: got x=%0d y=%0d dir=%0d lives=%0d score=%0d dead=%0d go=%0d w=%0d h=%0d; want x=%0d y=%0d dir=%0d lives=%0d score=%0d dead=%0d go=%0d w=%0d h=%0d",
                             nm, a.x, a.y, a.dir, a.lives, a.score, a.dead, a.go, a.w, a.h,
                             e.x, e.y, e.dir, e.lives, e.score, e.dead, e.go, e.w, e.h);
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(negedge Clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations still pending, want 0", exp_q.size());
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic ride(input int n, input logic signed [3:0] dx);
        ride_dx = dx;
        repeat (n) begin
            tick();
            ex = ex + int'(dx);
            if (ex < 0) ex = 0;
            if (ex > 600) ex = 600;
        end
    endtask

    task automatic hop_up(input bit goal);
        up = 1'b1;
        tick();
        edir = 0;
        expect_now("hop_launch");
        up = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 5 && goal) begin
                ex = 320; ey = 440; escore++; edir = 0;
            end else begin
                ey = ey - 8;
            end
        end
        expect_now(goal ? "goal_land" : "hop_land");
        tick();
    endtask

    task automatic die_by_car();
        Car_Collision = 4'b0100;
        tick();
        edead = 1;
        expect_now("car_death");
        Car_Collision = 4'd0;
        repeat (59) tick();
        expect_now("car_dead_hold");
        tick();
        elives--;
        if (elives == 0) begin
            ego = 1;
        end else begin
            ex = 320; ey = 440; edir = 0; edead = 0;
        end
        expect_now("car_death_end");
    endtask

    initial begin
        #2 Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        expect_now("reset");
        drain();
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // First hop with up held throughout: exactly one hop.
        up = 1'b1;
        tick();
        expect_now("up_press");
        for (int i = 0; i < 5; i++) begin
            tick();
            ey = ey - 8;
            expect_now("hop_step");
        end
        repeat (2) begin
            tick();
            expect_now("no_repeat");
        end
        up = 1'b0;
        tick();

        // Ride right into the right-edge clamp.
        LPad_Collision = 4'b0001;
        ride(1, 4'sd7);
        expect_now("ride_right");
        ride(44, 4'sd7);
        expect_now("ride_clamp_max");

        // Right at X=600: direction only, no hop.
        LPad_Collision = 4'd0;
        ride_dx = 4'd0;
        right = 1'b1;
        tick();
        edir = 2;
        expect_now("right_edge");
        tick();
        expect_now("right_edge_hold");
        right = 1'b0;
        tick();

        // Climb into the water rows on a pad.
        LPad_Collision = 4'b0010;
        repeat (6) hop_up(1'b0);

        // Ride left to 0, nudge to 6, then drift -3 into the left clamp.
        ride(76, -4'sd8);
        expect_now("ride_clamp_zero");
        ride(1, 4'sd6);
        expect_now("ride_to_6");
        for (int i = 0; i < 4; i++) begin
            ride(1, -4'sd3);
            expect_now("ride_left_clamp");
        end

        // Water with no pad: drown, then respawn after 60 ticks.
        ride_dx = 4'd0;
        LPad_Collision = 4'd0;
        tick();
        edead = 1;
        expect_now("water_death");
        repeat (59) tick();
        expect_now("water_dead_hold");
        tick();
        elives = 2; ex = 320; ey = 440; edir = 0; edead = 0;
        expect_now("water_respawn");
        LPad_Collision = 4'b0010;
        tick();

        // Nine hops to the top water row, then the goal hop.
        repeat (9) hop_up(1'b0);
        hop_up(1'b1);

        // Async reset in the middle of a hop.
        up = 1'b1;
        tick();
        up = 1'b0;
        tick();
        tick();
        ey = 424;
        expect_now("mid_hop");
        drain();
        @(negedge Clk);
        #1 Reset_n = 1'b0;
        ex = 320; ey = 440; edir = 0; elives = 3; escore = 0; edead = 0; ego = 0;
        expect_now("reset_mid_hop");
        drain();
        Reset_n = 1'b1;
        LPad_Collision = 4'd0;
        repeat (2) @(negedge Clk);

        // Three car deaths end the game.
        repeat (3) die_by_car();
        up = 1'b1;
        repeat (2) tick();
        expect_now("gameover_hold");
        up = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        elives = 3; escore = 0; ego = 0; edead = 0; ex = 320; ey = 440; edir = 0;
        expect_now("restart");

        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
